// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection, stage load/clear control, forwarding selects and stall/flush counters
//   clock, reset                 : rising-edge clock, asynchronous active-high reset
//   id_*                         : instruction currently in ID (operands, destination, kind)
//   ex_branch_taken, mem_busy    : branch resolution in EX, data-memory wait
//   pc_load, *_load, *_clear     : combinational controls for PC and the four stage registers
//   fwd_a, fwd_b                 : registered EX operand selects (00 regfile, 01 MEM/WB, 10 EX/MEM)
//   stall_cycles, flush_count    : saturating performance counters
module pipe_hazard_ctrl #(
    parameter int RegAddrWidth = 5,
    parameter int CntWidth = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [RegAddrWidth-1:0] id_rs1,
    input  logic [RegAddrWidth-1:0] id_rs2,
    input  logic                    id_use_rs1,
    input  logic                    id_use_rs2,
    input  logic [RegAddrWidth-1:0] id_rd,
    input  logic                    id_reg_write,
    input  logic                    id_mem_read,
    input  logic                    ex_branch_taken,
    input  logic                    mem_busy,
    output logic                    pc_load,
    output logic                    ifid_load,
    output logic                    ifid_clear,
    output logic                    idex_load,
    output logic                    idex_clear,
    output logic                    exmem_load,
    output logic                    exmem_clear,
    output logic                    memwb_load,
    output logic                    memwb_clear,
    output logic [1:0]              fwd_a,
    output logic [1:0]              fwd_b,
    output logic [CntWidth-1:0]     stall_cycles,
    output logic [CntWidth-1:0]     flush_count
);
    // Shadows of EX and MEM; WB is never forwarded from, so it needs no shadow.
    logic                    ex_v, ex_we, ex_mr, mem_v, mem_we;
    logic [RegAddrWidth-1:0] ex_rd, mem_rd;
    logic                    mem_stall, flush, load_use;
    logic [1:0]              fwd_a_next, fwd_b_next;

    assign mem_stall = mem_busy & mem_v;
    assign flush     = ex_branch_taken & ex_v;
    assign load_use  = ex_v & ex_mr & (ex_rd != '0) & id_valid &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // The younger producer (EX) wins over the older one (MEM).
    assign fwd_a_next = (id_use_rs1 && id_rs1 != '0 && ex_v && ex_we && ex_rd == id_rs1)    ? 2'b10 :
                        (id_use_rs1 && id_rs1 != '0 && mem_v && mem_we && mem_rd == id_rs1) ? 2'b01 : 2'b00;
    assign fwd_b_next = (id_use_rs2 && id_rs2 != '0 && ex_v && ex_we && ex_rd == id_rs2)    ? 2'b10 :
                        (id_use_rs2 && id_rs2 != '0 && mem_v && mem_we && mem_rd == id_rs2) ? 2'b01 : 2'b00;

    always_comb begin
        pc_load     = 1'b0;
        ifid_load   = 1'b0;
        ifid_clear  = 1'b0;
        idex_load   = 1'b0;
        idex_clear  = 1'b0;
        exmem_load  = 1'b0;
        exmem_clear = 1'b0;
        memwb_load  = 1'b0;
        memwb_clear = 1'b0;
        if (reset) begin
            ifid_clear  = 1'b1;
            idex_clear  = 1'b1;
            exmem_clear = 1'b1;
            memwb_clear = 1'b1;
        end else if (mem_stall) begin
            memwb_clear = 1'b1;
        end else if (flush) begin
            pc_load    = 1'b1;
            ifid_clear = 1'b1;
            idex_clear = 1'b1;
            exmem_load = 1'b1;
            memwb_load = 1'b1;
        end else if (load_use) begin
            idex_clear = 1'b1;
            exmem_load = 1'b1;
            memwb_load = 1'b1;
        end else begin
            pc_load    = 1'b1;
            ifid_load  = 1'b1;
            idex_load  = 1'b1;
            exmem_load = 1'b1;
            memwb_load = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_v         <= 1'b0;
            ex_rd        <= '0;
            ex_we        <= 1'b0;
            ex_mr        <= 1'b0;
            mem_v        <= 1'b0;
            mem_rd       <= '0;
            mem_we       <= 1'b0;
            fwd_a        <= 2'b00;
            fwd_b        <= 2'b00;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (idex_clear) begin
                ex_v <= 1'b0;
            end else if (idex_load) begin
                ex_v  <= id_valid;
                ex_rd <= id_rd;
                ex_we <= id_reg_write;
                ex_mr <= id_mem_read;
            end
            if (exmem_clear) begin
                mem_v <= 1'b0;
            end else if (exmem_load) begin
                mem_v  <= ex_v;
                mem_rd <= ex_rd;
                mem_we <= ex_we;
            end
            // A held MEM/WB select loses its producer to the register file during a stall.
            if (idex_clear) begin
                fwd_a <= 2'b00;
                fwd_b <= 2'b00;
            end else if (idex_load) begin
                fwd_a <= fwd_a_next;
                fwd_b <= fwd_b_next;
            end else if (mem_stall) begin
                fwd_a <= (fwd_a == 2'b01) ? 2'b00 : fwd_a;
                fwd_b <= (fwd_b == 2'b01) ? 2'b00 : fwd_b;
            end
            if (!pc_load && stall_cycles != '1)
                stall_cycles <= stall_cycles + CntWidth'(1);
            // Only a flush that actually fires is counted, not one waiting behind a stall.
            if (flush && !mem_stall && flush_count != '1)
                flush_count <= flush_count + CntWidth'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized checks of pipe_hazard_ctrl against an instruction-level model
module tb_pipe_hazard_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_branch_taken, mem_busy;
    logic       pc_load, ifid_load, ifid_clear, idex_load, idex_clear;
    logic       exmem_load, exmem_clear, memwb_load, memwb_clear;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cycles, flush_count;
    logic [8:0] ctrl;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct { bit v; int rd; bit we; bit mr; } inst_t;
    inst_t m_ex, m_mem;
    int m_fa, m_fb, m_stall, m_flush;

    localparam int A_RST = 0, A_STALL = 1, A_FLUSH = 2, A_LU = 3, A_RUN = 4;
    localparam logic [8:0] C_RST = 9'h055, C_STALL = 9'h001, C_FLUSH = 9'h15A, C_LU = 9'h01A, C_RUN = 9'h1AA;

    pipe_hazard_ctrl dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_load(pc_load), .ifid_load(ifid_load), .ifid_clear(ifid_clear),
        .idex_load(idex_load), .idex_clear(idex_clear),
        .exmem_load(exmem_load), .exmem_clear(exmem_clear),
        .memwb_load(memwb_load), .memwb_clear(memwb_clear),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // {pc, ifid load/clear, idex load/clear, exmem load/clear, memwb load/clear}
    assign ctrl = {pc_load, ifid_load, ifid_clear, idex_load, idex_clear,
                   exmem_load, exmem_clear, memwb_load, memwb_clear};

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] ctrl_of(input int act);
        return act == A_RST ? C_RST : act == A_STALL ? C_STALL : act == A_FLUSH ? C_FLUSH :
               act == A_LU ? C_LU : C_RUN;
    endfunction

    function automatic int fsel(input bit use_rs, input int rs);
        if (!use_rs || rs == 0) return 0;
        if (m_ex.v && m_ex.we && m_ex.rd == rs) return 2;
        if (m_mem.v && m_mem.we && m_mem.rd == rs) return 1;
        return 0;
    endfunction

    // One cycle: compare everything against the model, advance the model, move to the next negedge.
    task automatic tick();
        int act;
        bit lu;
        inst_t id_i;
        #1;
        if (reset) begin
            m_ex.v = 0; m_mem.v = 0; m_fa = 0; m_fb = 0; m_stall = 0; m_flush = 0;
        end
        lu = m_ex.v && m_ex.mr && m_ex.rd != 0 && id_valid &&
             ((id_use_rs1 && int'(id_rs1) == m_ex.rd) || (id_use_rs2 && int'(id_rs2) == m_ex.rd));
        act = reset ? A_RST : (mem_busy && m_mem.v) ? A_STALL :
              (ex_branch_taken && m_ex.v) ? A_FLUSH : lu ? A_LU : A_RUN;
        chk("ctrl", {23'b0, ctrl}, {23'b0, ctrl_of(act)});
        chk("fwd_a", {30'b0, fwd_a}, m_fa);
        chk("fwd_b", {30'b0, fwd_b}, m_fb);
        chk("stall_cycles", {16'b0, stall_cycles}, m_stall);
        chk("flush_count", {16'b0, flush_count}, m_flush);
        id_i.v = id_valid; id_i.rd = int'(id_rd); id_i.we = id_reg_write; id_i.mr = id_mem_read;
        case (act)
            A_RUN: begin
                m_fa = fsel(id_use_rs1, int'(id_rs1));
                m_fb = fsel(id_use_rs2, int'(id_rs2));
                m_mem = m_ex;
                m_ex = id_i;
            end
            A_FLUSH, A_LU: begin
                m_mem = m_ex;
                m_ex.v = 0;
                m_fa = 0;
                m_fb = 0;
            end
            A_STALL: begin
                if (m_fa == 1) m_fa = 0;
                if (m_fb == 1) m_fb = 0;
            end
            default: ;
        endcase
        if ((act == A_STALL || act == A_LU) && m_stall < 16'hFFFF) m_stall++;
        if (act == A_FLUSH && m_flush < 16'hFFFF) m_flush++;
        @(negedge clock);
    endtask

    task automatic set_in(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit we, input bit mr, input bit br, input bit busy);
        id_valid = v; id_rs1 = 5'(rs1); id_use_rs1 = u1; id_rs2 = 5'(rs2); id_use_rs2 = u2;
        id_rd = 5'(rd); id_reg_write = we; id_mem_read = mr; ex_branch_taken = br; mem_busy = busy;
    endtask

    task automatic nop();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rnd();
        set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
               $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 3),
               $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    endtask

    initial begin
        reset = 1'b1;
        nop();
        @(negedge clock);
        tick();
        tick();
        reset = 1'b0;
        repeat (300) begin rnd(); tick(); end

        // reset mid-stream while memory is busy
        rnd();
        mem_busy = 1'b1;
        reset = 1'b1;
        repeat (3) begin
            #1;
            chk("rst_ctrl", {23'b0, ctrl}, {23'b0, C_RST});
            chk("rst_fwd", {28'b0, fwd_a, fwd_b}, 0);
            chk("rst_cnt", {stall_cycles, flush_count}, 0);
            tick();
        end
        reset = 1'b0;
        nop();
        #1 chk("rel_ctrl", {23'b0, ctrl}, {23'b0, C_RUN});
        tick();

        // ALU forwarding: EX then MEM
        set_in(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
        set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("fwd_ex", {30'b0, fwd_a}, 2);
        set_in(1, 0, 0, 3, 1, 0, 0, 0, 0, 0); tick();
        chk("fwd_mem", {30'b0, fwd_b}, 1);
        chk("no_stall", {16'b0, stall_cycles}, 0);
        nop(); tick(); tick();

        // load-use: one bubble, then forward from MEM/WB
        set_in(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); tick();
        set_in(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("lu_ctrl", {23'b0, ctrl}, {23'b0, C_LU});
        tick();
        #1 chk("lu_after", {23'b0, ctrl}, {23'b0, C_RUN});
        tick();
        chk("lu_fwd", {30'b0, fwd_a}, 1);
        chk("lu_stall", {16'b0, stall_cycles}, 1);
        nop(); tick(); tick();

        // taken branch
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1 chk("br_ctrl", {23'b0, ctrl}, {23'b0, C_FLUSH});
        tick();
        nop();
        chk("br_cnt", {16'b0, flush_count}, 1);
        // taken branch held behind a 2-cycle memory stall
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        repeat (2) begin
            #1 chk("brs_ctrl", {23'b0, ctrl}, {23'b0, C_STALL});
            tick();
        end
        mem_busy = 1'b0;
        #1 chk("brs_fire", {23'b0, ctrl}, {23'b0, C_FLUSH});
        tick();
        nop();
        chk("brs_cnt", {16'b0, flush_count}, 2);

        // held MEM/WB select decays during a stall
        set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); tick();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        set_in(1, 7, 1, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("ms_fwd0", {30'b0, fwd_a}, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 chk("ms_ctrl", {23'b0, ctrl}, {23'b0, C_STALL});
        tick();
        chk("ms_fwd1", {30'b0, fwd_a}, 0);
        tick();
        tick();
        nop();
        chk("ms_stall", {16'b0, stall_cycles}, 6);

        // x0 producers never stall or forward
        set_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
        set_in(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        #1 chk("x0_alu", {23'b0, ctrl}, {23'b0, C_RUN});
        tick();
        chk("x0_alu_fwd", {28'b0, fwd_a, fwd_b}, 0);
        set_in(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); tick();
        set_in(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        #1 chk("x0_ld", {23'b0, ctrl}, {23'b0, C_RUN});
        tick();
        chk("x0_ld_fwd", {28'b0, fwd_a, fwd_b}, 0);

        // randomized traffic with occasional reset pulses
        repeat (3000) begin
            rnd();
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;

        // stall counter saturation
        reset = 1'b1; nop(); tick();
        reset = 1'b0;
        set_in(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); tick();
        nop(); tick();
        mem_busy = 1'b1;
        repeat (65534) tick();
        chk("sat_pre", {16'b0, stall_cycles}, 32'hFFFE);
        repeat (3) tick();
        chk("sat", {16'b0, stall_cycles}, 32'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
